prm_edge_sweep: RTL and testbench

PRM_EDGE_SWEEP -- requirements
Module: prm_edge_sweep

---
 rtl/prm_pkg.sv | 19 +
 rtl/prm_edge_sweep.sv | 138 +++++++++++++
 tb/tb_prm_edge_sweep.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prm_pkg.sv
// Shared definitions for the PRM edge-sweep block: default widths and the
// sweep controller state encoding.
package prm_pkg;

    // Obstacle-code width; one bit per checker input A..O.
    localparam int CODE_W = 15;

    // Width of the hit and accepted-code counters.
    localparam int CNT_W = 16;

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/prm_edge_sweep.sv
// Edge sweep controller: streams the obstacle codes of one roadmap edge to an
// external combinational edge checker, one code per cycle. It collects the
// blocked flag, the hit count and the accepted-code count, and then presents
// them as a single result. The checker lives outside this module, so any
// generated checker variant can be attached.
module prm_edge_sweep
    import prm_pkg::*;
#(
    parameter int CODE_W     = prm_pkg::CODE_W,
    parameter int CNT_W      = prm_pkg::CNT_W,
    parameter int EARLY_EXIT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_last,
    output logic [CODE_W-1:0] chk_code,
    input  logic              chk_mask,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_blocked,
    output logic [CNT_W-1:0]  res_hits,
    output logic [CNT_W-1:0]  res_count,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    sweep_state_t     state;
    sweep_state_t     state_nx;
    logic             probe;
    logic             last_pend;
    logic             blocked;
    logic [CNT_W-1:0] hits;
    logic [CNT_W-1:0] count;

    logic accept;
    logic hit;
    logic probe_nx;
    logic res_take;

    // The in_last code was accepted while probing, so its mask is still
    // outstanding. Input is paused for that one cycle so that the head of the
    // next list cannot be counted into this result.
    assign in_ready = !RST && (state != REPORT) && !last_pend;

    assign accept   = in_valid && in_ready;
    assign hit      = probe && chk_mask;
    assign probe_nx = accept && ((state == IDLE) || (state == RUN));
    assign res_take = (state == REPORT) && res_ready;

    assign res_valid   = (state == REPORT);
    assign res_blocked = blocked;
    assign res_hits    = hits;
    assign res_count   = count;
    assign busy        = (state != IDLE);

    // Next-state selection for the sweep controller.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last_pend) begin
                    state_nx = REPORT;
                end else if (accept && in_last) begin
                    state_nx = RUN;
                end else if (hit && (EARLY_EXIT != 0)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && in_last) begin
                    state_nx = REPORT;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register, probe pipeline and the registered checker code.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            probe     <= 1'b0;
            last_pend <= 1'b0;
            chk_code  <= '0;
        end else begin
            state <= state_nx;
            probe <= probe_nx;
            if (probe_nx) begin
                chk_code <= in_code;
            end
            if (probe_nx && in_last) begin
                last_pend <= 1'b1;
            end else if (state_nx == REPORT) begin
                last_pend <= 1'b0;
            end
        end
    end

    // Result accumulation: sticky blocked flag plus saturating counters,
    // cleared when the consumer takes the result.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blocked <= 1'b0;
            hits    <= '0;
            count   <= '0;
        end else if (res_take) begin
            blocked <= 1'b0;
            hits    <= '0;
            count   <= '0;
        end else begin
            if (hit) begin
                blocked <= 1'b1;
                if (hits != CNT_MAX) begin
                    hits <= hits + CNT_ONE;
                end
            end
            if (accept && (count != CNT_MAX)) begin
                count <= count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_prm_edge_sweep.sv
// Self-checking bench for prm_edge_sweep: directed lists plus randomized lists
// scored against a list-level reference model.
module tb_prm_edge_sweep;

    localparam int CW = 15;
    localparam int NA = 16;
    localparam int NB = 4;
    localparam int MAXA = 65535;
    localparam int MAXB = 15;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    logic          a_in_valid, a_in_ready, a_in_last, a_chk_mask;
    logic [CW-1:0] a_in_code, a_chk_code;
    logic          a_res_valid, a_res_ready, a_res_blocked, a_busy;
    logic [NA-1:0] a_res_hits, a_res_count;

    logic          b_in_valid, b_in_ready, b_in_last, b_chk_mask;
    logic [CW-1:0] b_in_code, b_chk_code;
    logic          b_res_valid, b_res_ready, b_res_blocked, b_busy;
    logic [NB-1:0] b_res_hits, b_res_count;

    logic [CW-1:0] obst;
    logic [CW-1:0] codes[$];

    int cyc = 0;
    int vectors = 0;
    int errors = 0;

    // Checker stand-in: an edge is blocked when its code touches an obstacle bit.
    assign a_chk_mask = |(a_chk_code & obst);
    assign b_chk_mask = |(b_chk_code & obst);

    prm_edge_sweep #(.CODE_W(CW), .CNT_W(NA), .EARLY_EXIT(1)) dut_a (
        .CLK(CLK), .RST(RST),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_code(a_in_code), .in_last(a_in_last),
        .chk_code(a_chk_code), .chk_mask(a_chk_mask),
        .res_valid(a_res_valid), .res_ready(a_res_ready), .res_blocked(a_res_blocked),
        .res_hits(a_res_hits), .res_count(a_res_count), .busy(a_busy)
    );

    prm_edge_sweep #(.CODE_W(CW), .CNT_W(NB), .EARLY_EXIT(0)) dut_b (
        .CLK(CLK), .RST(RST),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code), .in_last(b_in_last),
        .chk_code(b_chk_code), .chk_mask(b_chk_mask),
        .res_valid(b_res_valid), .res_ready(b_res_ready), .res_blocked(b_res_blocked),
        .res_hits(b_res_hits), .res_count(b_res_count), .busy(b_busy)
    );

    // Free-running clock and cycle counter.
    always #5 CLK = ~CLK;

    // Cycle index used for latency measurement.
    always @(posedge CLK) cyc <= cyc + 1;

    // Run-time bound so the bench always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired: observed running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic r_ready(input bit b);
        return b ? b_in_ready : a_in_ready;
    endfunction
    function automatic logic r_valid(input bit b);
        return b ? b_res_valid : a_res_valid;
    endfunction
    function automatic logic [31:0] r_hits(input bit b);
        return b ? 32'(b_res_hits) : 32'(a_res_hits);
    endfunction
    function automatic logic [31:0] r_count(input bit b);
        return b ? 32'(b_res_count) : 32'(a_res_count);
    endfunction
    function automatic logic r_blocked(input bit b);
        return b ? b_res_blocked : a_res_blocked;
    endfunction
    function automatic logic r_busy(input bit b);
        return b ? b_busy : a_busy;
    endfunction

    task automatic set_in(input bit b, input logic v, input logic [CW-1:0] c, input logic l);
        a_in_valid = 1'b0; a_in_code = '0; a_in_last = 1'b0;
        b_in_valid = 1'b0; b_in_code = '0; b_in_last = 1'b0;
        if (b) begin
            b_in_valid = v; b_in_code = c; b_in_last = l;
        end else begin
            a_in_valid = v; a_in_code = c; a_in_last = l;
        end
    endtask

    // Reference: count every code; probe all codes, or with early exit only up
    // to the first blocking code plus the one already in flight behind it.
    task automatic ref_model(input bit ee, input int maxv,
                             output int e_blk, output int e_hits, output int e_cnt, output int e_lat);
        int n = codes.size();
        int probed = n;
        bit drained = 1'b0;
        e_hits = 0;
        if (ee) begin
            for (int i = 0; i < n; i++) begin
                if (|(codes[i] & obst)) begin
                    probed = (i + 2 < n) ? i + 2 : n;
                    drained = (i + 2 < n);
                    break;
                end
            end
        end
        for (int i = 0; i < probed; i++) begin
            if (|(codes[i] & obst)) e_hits++;
        end
        e_blk = (e_hits > 0) ? 1 : 0;
        e_cnt = n;
        if (e_hits > maxv) e_hits = maxv;
        if (e_cnt > maxv) e_cnt = maxv;
        e_lat = drained ? n : n + 1;
    endtask

    // Offer the queued codes; one idle cycle is inserted after index gap_idx.
    task automatic apply_stimulus(input bit b, input int gap_idx, input bit mark_last, output int first_cyc);
        first_cyc = -1;
        for (int i = 0; i < codes.size(); i++) begin
            int t = 0;
            set_in(b, 1'b1, codes[i], mark_last && (i == codes.size() - 1));
            while (!r_ready(b) && t < 50) begin
                @(negedge CLK);
                t++;
            end
            if (t >= 50) begin
                check_output("accept_timeout", 32'(r_ready(b)), 32'd1);
                break;
            end
            if (first_cyc < 0) first_cyc = cyc;
            @(negedge CLK);
            if (i == gap_idx) begin
                set_in(b, 1'b0, '0, 1'b0);
                @(negedge CLK);
            end
        end
        set_in(b, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_result(input bit b, output int got_cyc);
        int t = 0;
        while (!r_valid(b) && t < 100) begin
            @(negedge CLK);
            t++;
        end
        got_cyc = cyc;
        if (t >= 100) check_output("result_timeout", 32'(r_valid(b)), 32'd1);
    endtask

    task automatic run_list(input string name, input bit b, input int gap_idx,
                            input int e_blk, input int e_hits, input int e_cnt, input int e_lat);
        int c0, c1;
        apply_stimulus(b, gap_idx, 1'b1, c0);
        wait_result(b, c1);
        if (e_lat >= 0) check_output({name, "_latency"}, 32'(c1 - c0), 32'(e_lat));
        check_output({name, "_blocked"}, 32'(r_blocked(b)), 32'(e_blk));
        check_output({name, "_hits"}, r_hits(b), 32'(e_hits));
        check_output({name, "_count"}, r_count(b), 32'(e_cnt));
    endtask

    task automatic finish_result(input string name, input bit b);
        if (b) b_res_ready = 1'b1; else a_res_ready = 1'b1;
        @(negedge CLK);
        a_res_ready = 1'b0;
        b_res_ready = 1'b0;
        check_output({name, "_ready_after"}, 32'(r_ready(b)), 32'd1);
        check_output({name, "_count_cleared"}, r_count(b), 32'd0);
    endtask

    task automatic run_model_list(input string name, input bit b);
        int eb, eh, ec, el;
        ref_model(!b, b ? MAXB : MAXA, eb, eh, ec, el);
        run_list(name, b, -1, eb, eh, ec, el);
        finish_result(name, b);
    endtask

    initial begin
        int dummy;
        set_in(1'b0, 1'b0, '0, 1'b0);
        a_res_ready = 1'b0;
        b_res_ready = 1'b0;
        obst = '0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        check_output("rst_in_ready_a", 32'(a_in_ready), 32'd0);
        check_output("rst_busy_a", 32'(a_busy), 32'd0);
        check_output("rst_res_valid_a", 32'(a_res_valid), 32'd0);
        check_output("rst_chk_code_a", 32'(a_chk_code), 32'd0);
        check_output("rst_hits_a", 32'(a_res_hits), 32'd0);
        check_output("rst_count_a", 32'(a_res_count), 32'd0);
        check_output("rst_blocked_a", 32'(a_res_blocked), 32'd0);
        check_output("rst_in_ready_b", 32'(b_in_ready), 32'd0);

        RST = 1'b0;
        #1;
        check_output("ready_after_rst_a", 32'(a_in_ready), 32'd1);
        check_output("ready_after_rst_b", 32'(b_in_ready), 32'd1);
        @(negedge CLK);

        obst = 15'h4000;
        codes = '{15'h0001, 15'h0002, 15'h0003};
        run_list("clear3", 1'b0, -1, 0, 0, 3, 4);
        finish_result("clear3", 1'b0);

        codes = '{15'h4005};
        run_list("single", 1'b0, -1, 1, 1, 1, 2);
        finish_result("single", 1'b0);

        codes = '{15'h4001, 15'h4002, 15'h4004, 15'h0001};
        run_list("inflight", 1'b0, -1, 1, 2, 4, 4);
        check_output("inflight_chk_code", 32'(a_chk_code), 32'h4002);
        finish_result("inflight", 1'b0);

        codes = '{15'h0011, 15'h4001, 15'h4002, 15'h0004};
        run_list("drain", 1'b0, 1, 1, 1, 4, -1);
        check_output("drain_chk_code", 32'(a_chk_code), 32'h4001);
        finish_result("drain", 1'b0);

        codes = '{15'h4001, 15'h0002, 15'h0004};
        run_list("ignore_mask", 1'b1, 0, 1, 1, 3, -1);
        finish_result("ignore_mask", 1'b1);

        codes = '{15'h4001, 15'h0001, 15'h4002, 15'h0002};
        run_list("no_early", 1'b1, -1, 1, 2, 4, 5);
        finish_result("no_early", 1'b1);

        codes = '{15'h4001, 15'h0003};
        run_list("hold", 1'b0, -1, 1, 1, 2, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check_output("hold_valid", 32'(a_res_valid), 32'd1);
            check_output("hold_in_ready", 32'(a_in_ready), 32'd0);
            check_output("hold_hits", 32'(a_res_hits), 32'd1);
            check_output("hold_count", 32'(a_res_count), 32'd2);
        end
        finish_result("hold", 1'b0);

        codes.delete();
        for (int i = 0; i < 19; i++) codes.push_back(15'h4001);
        run_list("saturate", 1'b1, -1, 1, MAXB, MAXB, 20);
        finish_result("saturate", 1'b1);

        codes = '{15'h4001, 15'h0002};
        apply_stimulus(1'b0, -1, 1'b0, dummy);
        RST = 1'b1;
        @(negedge CLK);
        check_output("midrst_valid", 32'(a_res_valid), 32'd0);
        check_output("midrst_count", 32'(a_res_count), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check_output("midrst_busy", 32'(a_busy), 32'd0);
        codes = '{15'h0002};
        run_list("after_rst", 1'b0, -1, 0, 0, 1, 2);
        finish_result("after_rst", 1'b0);

        codes = '{15'h4001};
        run_list("rpt_rst", 1'b0, -1, 1, 1, 1, 2);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        check_output("rpt_rst_valid", 32'(a_res_valid), 32'd0);
        check_output("rpt_rst_hits", 32'(a_res_hits), 32'd0);

        for (int k = 0; k < 12; k++) begin
            bit use_b = (k % 3 == 2);
            int n = $urandom_range(1, 8);
            obst = '0;
            for (int j = 0; j < 3; j++) obst[$urandom_range(0, CW - 1)] = 1'b1;
            codes.delete();
            for (int j = 0; j < n; j++) codes.push_back(CW'($urandom));
            run_model_list($sformatf("rand%0d", k), use_b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
